// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the EX stage: ALU opcodes, multiplier FSM states,
// link register number and the forwarding mux helper.
package ex_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned MUL_ITERS = 32;
  localparam int unsigned MUL_CNT_W = $clog2(MUL_ITERS);

  localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [OP_W-1:0] ALU_SLT = 3'd4;
  localparam logic [OP_W-1:0] ALU_LUI = 3'd5;
  localparam logic [OP_W-1:0] ALU_SLL = 3'd6;
  localparam logic [OP_W-1:0] ALU_MUL = 3'd7;

  localparam logic [REG_W-1:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

  // MEM has priority over WB; register 0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             rw_mem,
    input logic [REG_W-1:0] wr_mem,
    input logic [XLEN-1:0]  val_mem,
    input logic             rw_wb,
    input logic [REG_W-1:0] wr_wb,
    input logic [XLEN-1:0]  val_wb,
    input logic [XLEN-1:0]  reg_val
  );
    if (rw_mem && (wr_mem != '0) && (wr_mem == src)) return val_mem;
    if (rw_wb && (wr_wb != '0) && (wr_wb == src))    return val_wb;
    return reg_val;
  endfunction

endpackage

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier (32 iterations) with IDLE/BUSY/DONE control;
// stalls the pipeline from operand arrival until the product is ready.
module mult_seq
  import ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_stall_c,
  output logic [XLEN-1:0] o_product
);

  mul_state_e           r_state;
  mul_state_e           w_next_state;
  logic [MUL_CNT_W-1:0] r_count;
  logic [XLEN-1:0]      r_acc;
  logic [XLEN-1:0]      r_mcand;
  logic [XLEN-1:0]      r_mplier;
  logic                 w_load;
  logic                 w_step;
  logic                 w_stall;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) r_state <= MUL_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_stall      = 1'b0;
    unique case (r_state)
      MUL_IDLE: begin
        if (i_start && !i_flush) begin
          w_stall      = 1'b1;
          w_load       = 1'b1;
          w_next_state = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (i_flush) begin
          w_next_state = MUL_IDLE;
        end else begin
          w_stall = 1'b1;
          w_step  = 1'b1;
          if (r_count == MUL_CNT_W'(MUL_ITERS - 1)) w_next_state = MUL_DONE;
        end
      end
      MUL_DONE: w_next_state = MUL_IDLE;
      default:  w_next_state = MUL_IDLE;
    endcase
  end

  // Operands are captured once; forwarding changes while busy cannot disturb them.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (w_load) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= i_op_a;
      r_mplier <= i_op_b;
    end else if (w_step) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + MUL_CNT_W'(1);
    end
  end

  assign o_stall_c = w_stall & ~reset;
  assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Pipeline EX stage: forwarding, ALU, branch resolution and the EX/MEM register.
// Define EX_MULT_EN to build the iterative multiplier for ALUOp 7; otherwise MUL yields 0.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   PC4_ID_EX,
  input  logic [XLEN-1:0]   ReadData1_ID_EX,
  input  logic [XLEN-1:0]   ReadData2_ID_EX,
  input  logic [XLEN-1:0]   SignExtend_ID_EX,
  input  logic [REG_W-1:0]  Rs_ID_EX,
  input  logic [REG_W-1:0]  Rt_ID_EX,
  input  logic [REG_W-1:0]  Rd_ID_EX,
  input  logic [OP_W-1:0]   ALUOp_ID_EX,
  input  logic              RegDest_ID_EX,
  input  logic              ALUSrc_ID_EX,
  input  logic              BEQ_ID_EX,
  input  logic              BNE_ID_EX,
  input  logic              MemWrite_ID_EX,
  input  logic              MemRead_ID_EX,
  input  logic              MemtoReg_ID_EX,
  input  logic              RegWrite_ID_EX,
  input  logic              JAL_ID_EX,
  input  logic              RegWrite_MEM,
  input  logic [REG_W-1:0]  WriteReg_MEM,
  input  logic [XLEN-1:0]   ALUResult_MEM,
  input  logic              RegWrite_WB,
  input  logic [REG_W-1:0]  WriteReg_WB,
  input  logic [XLEN-1:0]   WriteData_WB,
  input  logic              Flush_EX,
  output logic [XLEN-1:0]   ALUResult_EX_MEM,
  output logic [XLEN-1:0]   WriteData_EX_MEM,
  output logic [REG_W-1:0]  WriteReg_EX_MEM,
  output logic              MemWrite_EX_MEM,
  output logic              MemRead_EX_MEM,
  output logic              MemtoReg_EX_MEM,
  output logic              RegWrite_EX_MEM,
  output logic              BranchTaken,
  output logic [XLEN-1:0]   BranchTarget,
  output logic              Stall_EX
);

  logic [XLEN-1:0]  w_op_a;
  logic [XLEN-1:0]  w_fwd_b;
  logic [XLEN-1:0]  w_alu_b;
  logic [XLEN-1:0]  w_alu_result;
  logic [XLEN-1:0]  w_result;
  logic [XLEN-1:0]  w_mul_product;
  logic [REG_W-1:0] w_write_reg;
  logic             w_stall;
  logic             w_eq;
  logic             w_bubble;

  assign w_op_a  = fwd_sel(Rs_ID_EX, RegWrite_MEM, WriteReg_MEM, ALUResult_MEM,
                           RegWrite_WB, WriteReg_WB, WriteData_WB, ReadData1_ID_EX);
  assign w_fwd_b = fwd_sel(Rt_ID_EX, RegWrite_MEM, WriteReg_MEM, ALUResult_MEM,
                           RegWrite_WB, WriteReg_WB, WriteData_WB, ReadData2_ID_EX);
  assign w_alu_b = ALUSrc_ID_EX ? SignExtend_ID_EX : w_fwd_b;

`ifdef EX_MULT_EN
  logic w_is_mul;
  assign w_is_mul = (ALUOp_ID_EX == ALU_MUL);

  mult_seq u_mult_seq (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_is_mul),
    .i_flush   (Flush_EX),
    .i_op_a    (w_op_a),
    .i_op_b    (w_alu_b),
    .o_stall_c (w_stall),
    .o_product (w_mul_product)
  );
`else
  assign w_mul_product = '0;
  assign w_stall       = 1'b0;
`endif

  always_comb begin
    w_alu_result = '0;
    case (ALUOp_ID_EX)
      ALU_ADD: w_alu_result = w_op_a + w_alu_b;
      ALU_SUB: w_alu_result = w_op_a - w_alu_b;
      ALU_AND: w_alu_result = w_op_a & w_alu_b;
      ALU_OR:  w_alu_result = w_op_a | w_alu_b;
      ALU_SLT: w_alu_result = XLEN'($signed(w_op_a) < $signed(w_alu_b));
      ALU_LUI: w_alu_result = {w_alu_b[15:0], 16'h0000};
      ALU_SLL: w_alu_result = w_alu_b << w_op_a[4:0];
      ALU_MUL: w_alu_result = w_mul_product;
      default: w_alu_result = '0;
    endcase
  end

  assign w_result    = JAL_ID_EX ? PC4_ID_EX : w_alu_result;
  assign w_write_reg = JAL_ID_EX ? LINK_REG : (RegDest_ID_EX ? Rd_ID_EX : Rt_ID_EX);

  // Branch compare uses the forwarded register value, never the immediate.
  assign w_eq         = (w_op_a == w_fwd_b);
  assign BranchTarget = PC4_ID_EX + (SignExtend_ID_EX << 2);
  assign Stall_EX     = w_stall;
  assign BranchTaken  = ((BEQ_ID_EX & w_eq) | (BNE_ID_EX & ~w_eq)) & ~Stall_EX & ~Flush_EX;
  assign w_bubble     = Stall_EX | Flush_EX;

  always_ff @(negedge clk or posedge reset) begin
    if (reset || w_bubble) begin
      ALUResult_EX_MEM <= '0;
      WriteData_EX_MEM <= '0;
      WriteReg_EX_MEM  <= '0;
      MemWrite_EX_MEM  <= 1'b0;
      MemRead_EX_MEM   <= 1'b0;
      MemtoReg_EX_MEM  <= 1'b0;
      RegWrite_EX_MEM  <= 1'b0;
    end else begin
      ALUResult_EX_MEM <= w_result;
      WriteData_EX_MEM <= w_fwd_b;
      WriteReg_EX_MEM  <= w_write_reg;
      MemWrite_EX_MEM  <= MemWrite_ID_EX;
      MemRead_EX_MEM   <= MemRead_ID_EX;
      MemtoReg_EX_MEM  <= MemtoReg_ID_EX;
      RegWrite_EX_MEM  <= RegWrite_ID_EX;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed, table-driven bench for ex_stage; multiplier sequences run when EX_MULT_EN is defined.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] PC4_ID_EX, ReadData1_ID_EX, ReadData2_ID_EX, SignExtend_ID_EX;
  logic [4:0]  Rs_ID_EX, Rt_ID_EX, Rd_ID_EX;
  logic [2:0]  ALUOp_ID_EX;
  logic        RegDest_ID_EX, ALUSrc_ID_EX, BEQ_ID_EX, BNE_ID_EX;
  logic        MemWrite_ID_EX, MemRead_ID_EX, MemtoReg_ID_EX, RegWrite_ID_EX, JAL_ID_EX;
  logic        RegWrite_MEM;
  logic [4:0]  WriteReg_MEM;
  logic [31:0] ALUResult_MEM;
  logic        RegWrite_WB;
  logic [4:0]  WriteReg_WB;
  logic [31:0] WriteData_WB;
  logic        Flush_EX;
  logic [31:0] ALUResult_EX_MEM, WriteData_EX_MEM;
  logic [4:0]  WriteReg_EX_MEM;
  logic        MemWrite_EX_MEM, MemRead_EX_MEM, MemtoReg_EX_MEM, RegWrite_EX_MEM;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Stall_EX;

  int checks   = 0;
  int failures = 0;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .PC4_ID_EX(PC4_ID_EX), .ReadData1_ID_EX(ReadData1_ID_EX), .ReadData2_ID_EX(ReadData2_ID_EX),
    .SignExtend_ID_EX(SignExtend_ID_EX), .Rs_ID_EX(Rs_ID_EX), .Rt_ID_EX(Rt_ID_EX), .Rd_ID_EX(Rd_ID_EX),
    .ALUOp_ID_EX(ALUOp_ID_EX), .RegDest_ID_EX(RegDest_ID_EX), .ALUSrc_ID_EX(ALUSrc_ID_EX),
    .BEQ_ID_EX(BEQ_ID_EX), .BNE_ID_EX(BNE_ID_EX), .MemWrite_ID_EX(MemWrite_ID_EX),
    .MemRead_ID_EX(MemRead_ID_EX), .MemtoReg_ID_EX(MemtoReg_ID_EX), .RegWrite_ID_EX(RegWrite_ID_EX),
    .JAL_ID_EX(JAL_ID_EX), .RegWrite_MEM(RegWrite_MEM), .WriteReg_MEM(WriteReg_MEM),
    .ALUResult_MEM(ALUResult_MEM), .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB),
    .WriteData_WB(WriteData_WB), .Flush_EX(Flush_EX),
    .ALUResult_EX_MEM(ALUResult_EX_MEM), .WriteData_EX_MEM(WriteData_EX_MEM),
    .WriteReg_EX_MEM(WriteReg_EX_MEM), .MemWrite_EX_MEM(MemWrite_EX_MEM),
    .MemRead_EX_MEM(MemRead_EX_MEM), .MemtoReg_EX_MEM(MemtoReg_EX_MEM),
    .RegWrite_EX_MEM(RegWrite_EX_MEM), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Stall_EX(Stall_EX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        alusrc, regdest, jal, beq, bne, flush;
    logic [3:0]  ctl;      // {MemWrite, MemRead, MemtoReg, RegWrite}
    logic        rw_mem;
    logic [4:0]  wr_mem;
    logic [31:0] alu_mem;
    logic        rw_wb;
    logic [4:0]  wr_wb;
    logic [31:0] wd_wb;
    logic [31:0] e_res, e_wd, e_tgt;
    logic [4:0]  e_wr;
    logic [3:0]  e_ctl;
    logic        e_taken;
  } vec_t;

  vec_t vq[$];
  vec_t v;
  vec_t v_add;

  task automatic drive(input vec_t x);
    ALUOp_ID_EX = x.op;  PC4_ID_EX = x.pc4;  ReadData1_ID_EX = x.rd1;  ReadData2_ID_EX = x.rd2;
    SignExtend_ID_EX = x.imm;  Rs_ID_EX = x.rs;  Rt_ID_EX = x.rt;  Rd_ID_EX = x.rd;
    ALUSrc_ID_EX = x.alusrc;  RegDest_ID_EX = x.regdest;  JAL_ID_EX = x.jal;
    BEQ_ID_EX = x.beq;  BNE_ID_EX = x.bne;  Flush_EX = x.flush;
    {MemWrite_ID_EX, MemRead_ID_EX, MemtoReg_ID_EX, RegWrite_ID_EX} = x.ctl;
    RegWrite_MEM = x.rw_mem;  WriteReg_MEM = x.wr_mem;  ALUResult_MEM = x.alu_mem;
    RegWrite_WB = x.rw_wb;  WriteReg_WB = x.wr_wb;  WriteData_WB = x.wd_wb;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ctl_out();
    return {MemWrite_EX_MEM, MemRead_EX_MEM, MemtoReg_EX_MEM, RegWrite_EX_MEM};
  endfunction

  task automatic chk_bubble(input string name);
    chk({name, "_res"}, ALUResult_EX_MEM, 32'h0);
    chk({name, "_ctl"}, 32'(ctl_out()), 32'h0);
  endtask

  initial begin
    // ADD 5+7 -> r3
    v = '0; v.op = ALU_ADD; v.rd1 = 5; v.rd2 = 7; v.rd = 3; v.regdest = 1; v.ctl = 4'b0001;
    v.e_res = 12; v.e_wd = 7; v.e_wr = 3; v.e_ctl = 4'b0001; vq.push_back(v); v_add = v;
    // MEM forward of r8 into A with ADDI 4
    v = '0; v.op = ALU_ADD; v.rs = 8; v.rt = 9; v.alusrc = 1; v.imm = 4; v.ctl = 4'b0001;
    v.rw_mem = 1; v.wr_mem = 8; v.alu_mem = 32'h10;
    v.e_res = 32'h14; v.e_wr = 9; v.e_ctl = 4'b0001; v.e_tgt = 32'h10; vq.push_back(v);
    // same with WriteReg_MEM=0: no forward
    v.wr_mem = 0; v.e_res = 4; vq.push_back(v);
    // Rs=0 must never be forwarded
    v = '0; v.op = ALU_ADD; v.rs = 0; v.rd1 = 1; v.alusrc = 1; v.imm = 4;
    v.rw_mem = 1; v.wr_mem = 0; v.alu_mem = 32'h55; v.e_res = 5; v.e_tgt = 32'h10; vq.push_back(v);
    // WB forward into B
    v = '0; v.op = ALU_ADD; v.rs = 2; v.rd1 = 3; v.rt = 5; v.rd = 4; v.regdest = 1;
    v.rw_wb = 1; v.wr_wb = 5; v.wd_wb = 32'h100;
    v.e_res = 32'h103; v.e_wd = 32'h100; v.e_wr = 4; vq.push_back(v);
    // MEM wins over WB
    v = '0; v.op = ALU_ADD; v.rs = 6; v.rd2 = 2; v.rw_mem = 1; v.wr_mem = 6; v.alu_mem = 32'hA;
    v.rw_wb = 1; v.wr_wb = 6; v.wd_wb = 32'hB; v.e_res = 32'hC; v.e_wd = 2; vq.push_back(v);
    // SUB with wrap
    v = '0; v.op = ALU_SUB; v.rd1 = 3; v.rd2 = 5; v.ctl = 4'b1000;
    v.e_res = 32'hFFFF_FFFE; v.e_wd = 5; v.e_ctl = 4'b1000; vq.push_back(v);
    // AND
    v = '0; v.op = ALU_AND; v.rd1 = 32'hF0F0_FFFF; v.rd2 = 32'h0FF0_00FF; v.ctl = 4'b0111;
    v.e_res = 32'h00F0_00FF; v.e_wd = 32'h0FF0_00FF; v.e_ctl = 4'b0111; vq.push_back(v);
    // OR
    v = '0; v.op = ALU_OR; v.rd1 = 32'hF000_0000; v.rd2 = 32'h0000_000F;
    v.e_res = 32'hF000_000F; v.e_wd = 32'hF; vq.push_back(v);
    // SLT signed both ways
    v = '0; v.op = ALU_SLT; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1; v.e_res = 1; v.e_wd = 1; vq.push_back(v);
    v = '0; v.op = ALU_SLT; v.rd1 = 1; v.rd2 = 32'hFFFF_FFFF; v.e_res = 0; v.e_wd = 32'hFFFF_FFFF; vq.push_back(v);
    // LUI: stored data is the register value, not the immediate
    v = '0; v.op = ALU_LUI; v.alusrc = 1; v.imm = 32'h1234; v.rd2 = 32'h77; v.rt = 10;
    v.e_res = 32'h1234_0000; v.e_wd = 32'h77; v.e_wr = 10; v.e_tgt = 32'h48D0; vq.push_back(v);
    // SLL uses only A[4:0]
    v = '0; v.op = ALU_SLL; v.rd1 = 32'h24; v.rd2 = 3; v.e_res = 32'h30; v.e_wd = 3; vq.push_back(v);
`ifndef EX_MULT_EN
    // MUL without the multiplier: single-cycle zero, no stall
    v = '0; v.op = ALU_MUL; v.rd1 = 6; v.rd2 = 7; v.rd = 12; v.regdest = 1; v.ctl = 4'b0001;
    v.e_res = 0; v.e_wd = 7; v.e_wr = 12; v.e_ctl = 4'b0001; vq.push_back(v);
`endif
    // JAL overrides result and destination
    v = '0; v.op = ALU_ADD; v.jal = 1; v.pc4 = 32'h0040_0008; v.rd1 = 1; v.rd2 = 2; v.rd = 7;
    v.regdest = 1; v.ctl = 4'b0001;
    v.e_res = 32'h0040_0008; v.e_wd = 2; v.e_wr = 31; v.e_ctl = 4'b0001; v.e_tgt = 32'h0040_0008;
    vq.push_back(v);
    // BEQ taken / BNE not taken / BNE taken
    v = '0; v.op = ALU_SUB; v.beq = 1; v.rd1 = 9; v.rd2 = 9; v.pc4 = 32'h0040_0010; v.imm = 3;
    v.e_res = 0; v.e_wd = 9; v.e_tgt = 32'h0040_001C; v.e_taken = 1; vq.push_back(v);
    v.beq = 0; v.bne = 1; v.e_taken = 0; vq.push_back(v);
    v.rd2 = 8; v.e_res = 1; v.e_wd = 8; v.e_taken = 1; vq.push_back(v);
    // Flush squashes branch and loads a bubble
    v = '0; v.op = ALU_SUB; v.beq = 1; v.rd1 = 9; v.rd2 = 9; v.regdest = 1; v.rd = 5;
    v.ctl = 4'b0001; v.flush = 1; v.e_taken = 0; vq.push_back(v);
    // Branch compares forwarded B, not the immediate; negative offset
    v = '0; v.op = ALU_SUB; v.beq = 1; v.rd1 = 9; v.rt = 4; v.alusrc = 1; v.imm = 32'hFFFF_FFFF;
    v.pc4 = 32'h100; v.rw_mem = 1; v.wr_mem = 4; v.alu_mem = 9;
    v.e_res = 10; v.e_wd = 9; v.e_wr = 4; v.e_tgt = 32'hFC; v.e_taken = 1; vq.push_back(v);

    // reset state, with a MUL presented so Stall_EX must stay low
    reset = 1'b1;
    v = v_add; v.op = ALU_MUL; drive(v);
    #2;
    chk("rst_stall", 32'(Stall_EX), 0);
    chk_bubble("rst");
    chk("rst_wd", WriteData_EX_MEM, 0);
    chk("rst_wr", 32'(WriteReg_EX_MEM), 0);
    @(negedge clk); #1;
    chk_bubble("rst_edge");
    reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i]);
      #2;
      chk($sformatf("v%0d_taken", i), 32'(BranchTaken), 32'(vq[i].e_taken));
      chk($sformatf("v%0d_tgt", i), BranchTarget, vq[i].e_tgt);
      chk($sformatf("v%0d_stall", i), 32'(Stall_EX), 0);
      @(negedge clk); #1;
      chk($sformatf("v%0d_res", i), ALUResult_EX_MEM, vq[i].e_res);
      chk($sformatf("v%0d_wd", i), WriteData_EX_MEM, vq[i].e_wd);
      chk($sformatf("v%0d_wr", i), 32'(WriteReg_EX_MEM), 32'(vq[i].e_wr));
      chk($sformatf("v%0d_ctl", i), 32'(ctl_out()), 32'(vq[i].e_ctl));
    end

    // asynchronous reset clears loaded outputs between edges
    drive(v_add);
    @(negedge clk); #1;
    chk("pre_rst_res", ALUResult_EX_MEM, 12);
    #2 reset = 1'b1;
    #1;
    chk_bubble("async_rst");
    chk("async_rst_wr", 32'(WriteReg_EX_MEM), 0);
    @(negedge clk); #1;
    reset = 1'b0;

`ifdef EX_MULT_EN
    // 0xFFFFFFFF * 3: 33 stall cycles of bubbles, forwarding change while busy ignored
    v = '0; v.op = ALU_MUL; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 3; v.rs = 1; v.rt = 2;
    v.regdest = 1; v.rd = 13; v.ctl = 4'b0001;
    drive(v);
    for (int k = 0; k < 33; k++) begin
      #2;
      chk($sformatf("mul_stall_%0d", k), 32'(Stall_EX), 1);
      if (k == 1) begin
        RegWrite_MEM = 1'b1; WriteReg_MEM = 5'd1; ALUResult_MEM = 32'h1234;
      end
      @(negedge clk); #1;
      chk_bubble($sformatf("mul_bub_%0d", k));
    end
    #2;
    chk("mul_done_stall", 32'(Stall_EX), 0);
    @(negedge clk); #1;
    chk("mul_res", ALUResult_EX_MEM, 32'hFFFF_FFFD);
    chk("mul_wr", 32'(WriteReg_EX_MEM), 13);
    chk("mul_wd", WriteData_EX_MEM, 3);
    chk("mul_ctl", 32'(ctl_out()), 1);

    // flush at BUSY iteration 10
    v = '0; v.op = ALU_MUL; v.rd1 = 5; v.rd2 = 6; v.regdest = 1; v.rd = 2; v.ctl = 4'b0001;
    drive(v);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk); #1;
    end
    Flush_EX = 1'b1;
    #2;
    chk("flush_stall", 32'(Stall_EX), 0);
    @(negedge clk); #1;
    chk_bubble("flush_bub");
    drive(v_add);
    #2;
    chk("post_flush_stall", 32'(Stall_EX), 0);
    @(negedge clk); #1;
    chk("post_flush_res", ALUResult_EX_MEM, 12);

    // reset mid-BUSY
    drive(v);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("busy_rst_stall", 32'(Stall_EX), 0);
    chk_bubble("busy_rst");
    @(negedge clk); #1;
    reset = 1'b0;
    drive(v_add);
    #2;
    chk("post_rst_stall", 32'(Stall_EX), 0);
    @(negedge clk); #1;
    chk("post_rst_res", ALUResult_EX_MEM, 12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
